alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: 0 = main pipeline execute stage, 1 = auxiliary unit such as address generation or branch compare.
- Round-robin arbitration with valid/ready handshakes on both sides.
- The operand mux drives the ALU from the granted requester; the ALU result is captured in a one-entry output register tagged with requester ID and a caller tag.
- Sits between the requesters and the ALU instance.

---
 rtl/alu_arbiter_if.sv | 54 +++++
 rtl/alu_arbiter.sv | 82 ++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between the two ALU requesters, the shared ALU and the result consumer.
// The slave modport is the arbiter's view. The master modport is the view of the surrounding logic.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 4
);
    logic                     req0_valid;
    logic                     req0_ready;
    logic [DATA_WIDTH-1:0]    req0_srca;
    logic [DATA_WIDTH-1:0]    req0_srcb;
    logic [OPCODE_LENGTH-1:0] req0_op;
    logic [TAG_WIDTH-1:0]     req0_tag;

    logic                     req1_valid;
    logic                     req1_ready;
    logic [DATA_WIDTH-1:0]    req1_srca;
    logic [DATA_WIDTH-1:0]    req1_srcb;
    logic [OPCODE_LENGTH-1:0] req1_op;
    logic [TAG_WIDTH-1:0]     req1_tag;

    logic [DATA_WIDTH-1:0]    alu_srca;
    logic [DATA_WIDTH-1:0]    alu_srcb;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]    alu_result;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic                     rsp_id;
    logic [TAG_WIDTH-1:0]     rsp_tag;
    logic [DATA_WIDTH-1:0]    rsp_result;

    modport slave (
        input  req0_valid, req0_srca, req0_srcb, req0_op, req0_tag,
        output req0_ready,
        input  req1_valid, req1_srca, req1_srcb, req1_op, req1_tag,
        output req1_ready,
        output alu_srca, alu_srcb, alu_op,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_tag, rsp_result,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_srca, req0_srcb, req0_op, req0_tag,
        input  req0_ready,
        output req1_valid, req1_srca, req1_srcb, req1_op, req1_tag,
        input  req1_ready,
        input  alu_srca, alu_srcb, alu_op,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// The result is held in a one-entry output register that carries the requester id and the caller tag.
module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 4
) (
    input  logic clk,
    input  logic rst_n,
    alu_arbiter_if.slave bus
);
    logic                  rr_ptr;
    logic                  rsp_valid_q;
    logic                  rsp_id_q;
    logic [TAG_WIDTH-1:0]  rsp_tag_q;
    logic [DATA_WIDTH-1:0] rsp_result_q;

    logic                  slot_free;
    logic                  grant_valid;
    logic                  grant_id;
    logic                  fire;
    logic [TAG_WIDTH-1:0]  grant_tag;

    assign slot_free = !rsp_valid_q || bus.rsp_ready;

    always_comb begin
        grant_valid = bus.req0_valid || bus.req1_valid;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant_id = rr_ptr;
        else if (bus.req1_valid)
            grant_id = 1'b1;
    end

    // The grant is held while the slot is busy. A stalled requester therefore keeps the ALU inputs steady.
    always_comb begin
        bus.alu_srca = '0;
        bus.alu_srcb = '0;
        bus.alu_op   = '0;
        grant_tag    = '0;
        if (grant_valid) begin
            if (grant_id) begin
                bus.alu_srca = bus.req1_srca;
                bus.alu_srcb = bus.req1_srcb;
                bus.alu_op   = bus.req1_op;
                grant_tag    = bus.req1_tag;
            end else begin
                bus.alu_srca = bus.req0_srca;
                bus.alu_srcb = bus.req0_srcb;
                bus.alu_op   = bus.req0_op;
                grant_tag    = bus.req0_tag;
            end
        end
    end

    assign bus.req0_ready = rst_n && slot_free && grant_valid && !grant_id;
    assign bus.req1_ready = rst_n && slot_free && grant_valid &&  grant_id;
    assign fire           = grant_valid && slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
        end else if (fire) begin
            rr_ptr       <= ~grant_id;
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= grant_id;
            rsp_tag_q    <= grant_tag;
            rsp_result_q <= bus.alu_result;
        end else if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_result = rsp_result_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. A small behavioural ALU closes the loop on the operand mux.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam int TW = 4;

    localparam logic [OW-1:0] OP_AND = 4'b0000;
    localparam logic [OW-1:0] OP_OR  = 4'b0001;
    localparam logic [OW-1:0] OP_ADD = 4'b0010;
    localparam logic [OW-1:0] OP_SUB = 4'b0110;
    localparam logic [OW-1:0] OP_UNS = 4'b0111;
    localparam logic [OW-1:0] OP_EQ  = 4'b1000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .TAG_WIDTH(TW)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_fn(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_EQ:   return (a == b) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    always_comb bus.alu_result = alu_fn(bus.alu_op, bus.alu_srca, bus.alu_srcb);

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic set0(input logic v, input logic [OW-1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [TW-1:0] t);
        bus.req0_valid = v; bus.req0_op = op; bus.req0_srca = a; bus.req0_srcb = b; bus.req0_tag = t;
    endtask

    task automatic set1(input logic v, input logic [OW-1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [TW-1:0] t);
        bus.req1_valid = v; bus.req1_op = op; bus.req1_srca = a; bus.req1_srcb = b; bus.req1_tag = t;
    endtask

    initial begin
        // reset state, with a request already pending
        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        set0(1'b1, OP_ADD, 32'd1, 32'd1, 4'd1);
        set1(1'b0, OP_AND, 32'd0, 32'd0, 4'd0);
        #2;
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_id", bus.rsp_id, 0);
        chk("rst_tag", bus.rsp_tag, 0);
        chk("rst_result", bus.rsp_result, 0);
        #5;
        chk("rst_valid_after_edge", bus.rsp_valid, 0);
        set0(1'b0, OP_AND, 32'd0, 32'd0, 4'd0);
        #1 rst_n = 1'b1;

        // single issue
        tick();
        set0(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3);
        #1;
        chk("single_ready0", bus.req0_ready, 1);
        chk("single_ready1", bus.req1_ready, 0);
        chk("single_alu_op", bus.alu_op, OP_ADD);
        chk("single_alu_srca", bus.alu_srca, 5);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("single_rsp_valid", bus.rsp_valid, 1);
        chk("single_rsp_result", bus.rsp_result, 12);
        chk("single_rsp_id", bus.rsp_id, 0);
        chk("single_rsp_tag", bus.rsp_tag, 3);
        tick();
        chk("single_drain", bus.rsp_valid, 0);
        chk("single_hold_result", bus.rsp_result, 12);

        // contention after reset
        pulse_reset();
        tick();
        set0(1'b1, OP_SUB, 32'd10, 32'd3, 4'd1);
        set1(1'b1, OP_OR, 32'hF0, 32'h0F, 4'd2);
        #1;
        chk("cont_ready0", bus.req0_ready, 1);
        chk("cont_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("cont_rsp0_id", bus.rsp_id, 0);
        chk("cont_rsp0_result", bus.rsp_result, 7);
        chk("cont_rsp0_tag", bus.rsp_tag, 1);
        chk("cont_ready1_second", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        #1;
        chk("cont_rsp1_id", bus.rsp_id, 1);
        chk("cont_rsp1_result", bus.rsp_result, 32'hFF);
        chk("cont_rsp1_tag", bus.rsp_tag, 2);
        tick();
        chk("cont_drain", bus.rsp_valid, 0);

        // backpressure: fill the slot from req0, which moves rr_ptr to 1, then stall
        bus.rsp_ready = 1'b0;
        set0(1'b1, OP_ADD, 32'd1, 32'd1, 4'd5);
        tick();
        set0(1'b1, OP_AND, 32'hC, 32'hA, 4'd6);
        set1(1'b1, OP_EQ, 32'h55, 32'h55, 4'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", bus.rsp_valid, 1);
            chk("stall_result", bus.rsp_result, 2);
            chk("stall_id", bus.rsp_id, 0);
            chk("stall_tag", bus.rsp_tag, 5);
            chk("stall_ready0", bus.req0_ready, 0);
            chk("stall_ready1", bus.req1_ready, 0);
            chk("stall_alu_op", bus.alu_op, OP_EQ);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_accept_ready1", bus.req1_ready, 1);
        chk("bp_accept_ready0", bus.req0_ready, 0);
        tick();
        bus.req1_valid = 1'b0;
        #1;
        chk("bp_rsp_result", bus.rsp_result, 1);
        chk("bp_rsp_id", bus.rsp_id, 1);
        chk("bp_rsp_tag", bus.rsp_tag, 9);
        chk("bp_next_ready0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("bp_req0_result", bus.rsp_result, 8);
        chk("bp_req0_id", bus.rsp_id, 0);
        tick();

        // fairness stream, starting from reset
        pulse_reset();
        tick();
        set0(1'b1, OP_ADD, 32'd0, 32'd3, 4'd0);
        set1(1'b1, OP_ADD, 32'd16, 32'd3, 4'd8);
        for (int i = 0; i < 8; i++) begin
            int k;
            int j;
            k = i % 2;
            j = i / 2;
            #1;
            chk("fair_ready0", bus.req0_ready, (k == 0) ? 1 : 0);
            chk("fair_ready1", bus.req1_ready, (k == 1) ? 1 : 0);
            tick();
            chk("fair_rsp_valid", bus.rsp_valid, 1);
            chk("fair_rsp_id", bus.rsp_id, k);
            chk("fair_rsp_result", bus.rsp_result, 16 * k + j + 3);
            chk("fair_rsp_tag", bus.rsp_tag, 8 * k + j);
            if (k == 0) set0(1'b1, OP_ADD, 32'(j + 1), 32'd3, 4'(j + 1));
            else        set1(1'b1, OP_ADD, 32'(16 + j + 1), 32'd3, 4'(8 + j + 1));
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();

        // idle and unsupported op
        #1;
        chk("idle_alu_op", bus.alu_op, 0);
        chk("idle_alu_srca", bus.alu_srca, 0);
        chk("idle_alu_srcb", bus.alu_srcb, 0);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        tick();
        chk("idle_rsp_valid_2", bus.rsp_valid, 0);
        set0(1'b1, OP_UNS, 32'd3, 32'd4, 4'd1);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("uns_rsp_valid", bus.rsp_valid, 1);
        chk("uns_rsp_result", bus.rsp_result, 0);
        tick();

        // reset mid-operation
        bus.rsp_ready = 1'b0;
        set0(1'b1, OP_ADD, 32'd20, 32'd22, 4'd7);
        tick();
        set1(1'b1, OP_OR, 32'd1, 32'd2, 4'd3);
        #1;
        chk("mid_full_valid", bus.rsp_valid, 1);
        chk("mid_full_result", bus.rsp_result, 42);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.rsp_valid, 0);
        chk("mid_rst_ready0", bus.req0_ready, 0);
        chk("mid_rst_ready1", bus.req1_ready, 0);
        chk("mid_rst_result", bus.rsp_result, 0);
        chk("mid_rst_tag", bus.rsp_tag, 0);
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("post_rst_ready0", bus.req0_ready, 1);
        chk("post_rst_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("post_rst_id", bus.rsp_id, 0);
        chk("post_rst_result", bus.rsp_result, 42);
        tick();
        bus.req1_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
